// File: rtl/chimera_clu_gate_seq.sv
// chimera_clu_gate_seq: per-cluster isolate/drain/reset/clock-gate sequencer (clk_i, rst_i, gate_req_i, clu_busy_i -> clk_en_o, clu_rst_no, isolate_o, gated_o, state_o)
module chimera_clu_gate_seq #(
  parameter int NumClusters = 5,
  parameter int IdleCycles  = 4,
  parameter int RstCycles   = 8,
  parameter int CntWidth    = $clog2((IdleCycles > RstCycles ? IdleCycles : RstCycles) + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumClusters-1:0]   gate_req_i,
  input  logic [NumClusters-1:0]   clu_busy_i,
  output logic [NumClusters-1:0]   clk_en_o,
  output logic [NumClusters-1:0]   clu_rst_no,
  output logic [NumClusters-1:0]   isolate_o,
  output logic [NumClusters-1:0]   gated_o,
  output logic [3*NumClusters-1:0] state_o
);
  typedef enum logic [2:0] {RUN = 3'd0, ISO = 3'd1, RST = 3'd2, GATED = 3'd3, WAKE = 3'd4} state_e;
  localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
  localparam logic [CntWidth-1:0] RstLoad  = CntWidth'(RstCycles - 1);
  state_e              state_q [NumClusters];
  state_e              state_d [NumClusters];
  logic [CntWidth-1:0] cnt_q   [NumClusters];
  logic [CntWidth-1:0] cnt_d   [NumClusters];
  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RUN: begin
          state_d[i] = gate_req_i[i] ? ISO : RUN;
          cnt_d[i]   = gate_req_i[i] ? '0 : cnt_q[i];
        end
        ISO: begin
          if (!gate_req_i[i]) state_d[i] = RUN;
          else if (clu_busy_i[i]) cnt_d[i] = '0;
          else if (cnt_q[i] >= IdleLast) begin
            state_d[i] = RST;
            cnt_d[i]   = RstLoad;
          end else cnt_d[i] = cnt_q[i] + 1'b1;
        end
        RST: begin
          state_d[i] = (cnt_q[i] == '0) ? GATED : RST;
          cnt_d[i]   = (cnt_q[i] == '0) ? cnt_q[i] : cnt_q[i] - 1'b1;
        end
        GATED: begin
          state_d[i] = gate_req_i[i] ? GATED : WAKE;
          cnt_d[i]   = gate_req_i[i] ? cnt_q[i] : RstLoad;
        end
        WAKE: begin
          state_d[i] = (cnt_q[i] == '0) ? RUN : WAKE;
          cnt_d[i]   = (cnt_q[i] == '0) ? cnt_q[i] : cnt_q[i] - 1'b1;
        end
        default: begin
          state_d[i] = WAKE;
          cnt_d[i]   = RstLoad;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumClusters; i++) begin
      state_q[i] <= rst_i ? WAKE : state_d[i];
      cnt_q[i]   <= rst_i ? RstLoad : cnt_d[i];
    end
  end
  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      clk_en_o[i]      = state_q[i] != GATED;
      clu_rst_no[i]    = (state_q[i] == RUN) || (state_q[i] == ISO);
      isolate_o[i]     = state_q[i] != RUN;
      gated_o[i]       = state_q[i] == GATED;
      state_o[3*i +: 3] = state_q[i];
    end
  end
endmodule

// File: doc/chimera_clu_gate_seq.md
# chimera_clu_gate_seq

Per-cluster clock/reset sequencer between the top-level register file and the cluster clock gates. Turns each cluster's level "gate request" bit into a safe power-down/power-up sequence: isolate the cluster from the SoC AXI fabric, wait for outstanding traffic to drain, hold the cluster in reset with its clock running, then stop the clock. Wake-up reverses the order. Outputs drive the `tc_clk_gating` enables, the cluster reset and the AXI isolation controls of the cluster domain.

## Interface
Parameters:
- `NumClusters`, 5: number of independently sequenced clusters.
- `IdleCycles`, 4: consecutive idle cycles required in ISO before reset; must be at least 1.
- `RstCycles`, 8: cycles reset is held with the clock running, both on entry to GATED and in WAKE; must be at least 1.
- `CntWidth`, `$clog2(max(IdleCycles,RstCycles)+1)`: width of the per-cluster counter; derived, do not override.

Ports:
- `clk_i` in, 1: SoC clock.
- `rst_i` in, 1: reset; synchronous, active-high.
- `gate_req_i` in, `NumClusters`: 1 requests gating of cluster i; level, quasi-static, from the register file.
- `clu_busy_i` in, `NumClusters`: 1 means cluster i has outstanding AXI transactions, narrow or wide, in either direction.
- `clk_en_o` out, `NumClusters`: clock-gate enable; 1 means the clock runs.
- `clu_rst_no` out, `NumClusters`: cluster reset, active-low.
- `isolate_o` out, `NumClusters`: 1 means the cluster's AXI ports are isolated and new transactions are blocked.
- `gated_o` out, `NumClusters`: 1 when cluster i is in GATED; status readback.
- `state_o` out, `NumClusters`×3: encoded FSM state per cluster.

## Operation
- There is one independent FSM and one counter per cluster; clusters never interact.
- All outputs are decoded directly from the state register and are therefore glitch-free.
- State encodings: RUN=0, ISO=1, RST=2, GATED=3, WAKE=4.

Output values per state:
- RUN: `clk_en`=1, `rst_n`=1, `isolate`=0.
- ISO: `clk_en`=1, `rst_n`=1, `isolate`=1.
- RST: `clk_en`=1, `rst_n`=0, `isolate`=1.
- GATED: `clk_en`=0, `rst_n`=0, `isolate`=1, `gated`=1.
- WAKE: `clk_en`=1, `rst_n`=0, `isolate`=1.

Transitions:
- RUN → ISO when `gate_req`=1. The counter is cleared.
- ISO:
  - If `gate_req`=0, go to RUN (abort). This has priority over the drain check.
  - Otherwise, if `busy`=1, clear the counter.
  - Otherwise, increment the counter. When the counter reaches `IdleCycles` (the cycle in which the count becomes `IdleCycles`), go to RST and load the counter with `RstCycles-1`.
- RST: decrement each cycle. At count 0, go to GATED. RST is not abortable; a dropped request is handled from GATED.
- GATED → WAKE when `gate_req`=0. The counter is loaded with `RstCycles-1`.
- WAKE: decrement each cycle. At count 0, go to RUN, which releases reset and isolation in the same edge. WAKE ignores `gate_req`; a new request is honoured from RUN on the next cycle.
- `clu_busy_i` is ignored in every state except ISO.
- The counter saturates and never wraps.

Reset:
- On `rst_i` all FSMs enter WAKE with the counter loaded with `RstCycles-1`.
- Reset values of the outputs are therefore: `clk_en_o`=all 1, `clu_rst_no`=all 0, `isolate_o`=all 1, `gated_o`=0, `state_o`=4 per cluster.
- After reset deasserts, clusters leave reset following `RstCycles` cycles of running clock.
- Asserting `rst_i` mid-sequence from any state overrides everything and applies the same reset values on the next edge.

## Timing
- Request to isolation: `gate_req` sampled high at edge k puts `isolate_o`=1 after edge k, a latency of 1 cycle.
- Drain with no traffic: ISO lasts exactly `IdleCycles` cycles.
- Reset hold: RST lasts exactly `RstCycles` cycles, as does WAKE.
- Minimum request-to-`clk_en_o`=0 is `1 + IdleCycles + RstCycles` cycles.
- Release-to-RUN: `gate_req` sampled low in GATED at edge k gives `clk_en_o`=1 after edge k; `clu_rst_no`/`isolate_o` deassert `RstCycles` cycles later.
- A busy pulse in ISO restarts the full `IdleCycles` window.
- With `rst_i` held high, outputs stay at their reset values and the counter stays loaded.

## Test plan
All cases use `IdleCycles`=4 and `RstCycles`=8.
- **Reset release:** deassert `rst_i` at cycle 0 → `clu_rst_no`=0 and `isolate_o`=1 for cycles 0–7; both deassert after edge 8; `clk_en_o`=1 throughout.
- **Clean gate:** `gate_req[2]`=1 at cycle 0, `busy`=0 → `isolate_o[2]`=1 at cycle 1; `clu_rst_no[2]`=0 at cycle 5; `clk_en_o[2]`=0 and `gated_o[2]`=1 at cycle 13; other clusters unaffected.
- **Drain restart:** in ISO, `busy[1]` toggles 1 at idle count 3 → counter restarts; RST is entered only after 4 further consecutive idle cycles.
- **Abort in ISO:** `gate_req[0]` drops during ISO → RUN on the next cycle, `isolate_o[0]`=0, reset never asserted.
- **Wake plus immediate re-request:** from GATED, drop then re-raise `gate_req[4]` → full 8-cycle WAKE, one RUN cycle, then ISO.
- **Mid-sequence reset and simultaneous requests:** `rst_i` during RST for all 5 clusters gated simultaneously → all `state_o`=4 next cycle; all clusters sequence independently with identical timing.
